// File: rtl/uart_rx_deserializer.sv
// rtl/uart_rx_deserializer.sv - oversampling UART receiver with majority vote and stop check
// Parity state, parity check and o_par_err are built only when UART_RX_PARITY_EN is defined.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rx_in,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  output logic [DATA_WIDTH-1:0] o_p_data,
  output logic                  o_data_valid,
  output logic                  o_par_err,
  output logic                  o_stop_err,
  output logic                  o_busy
);

  localparam int TW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int M  = PRESCALE / 2;

  localparam logic [TW-1:0] TICK_A    = TW'(M - 1);
  localparam logic [TW-1:0] TICK_B    = TW'(M);
  localparam logic [TW-1:0] TICK_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]            state;
  logic [TW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  rx_meta, rx_s, rx_prev;
  logic                  samp_a, samp_b;
  logic                  vote, decide, bit_end;

  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign decide  = (tick_cnt == TICK_DEC);
  assign bit_end = (tick_cnt == TICK_LAST);
  assign o_busy  = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_typ_q, par_bad, par_err_q;
  assign o_par_err = par_err_q;
`else
  logic unused_par_inputs;
  assign unused_par_inputs = i_par_en ^ i_par_typ;
  assign o_par_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= S_IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      rx_meta      <= 1'b1;
      rx_s         <= 1'b1;
      rx_prev      <= 1'b1;
      samp_a       <= 1'b1;
      samp_b       <= 1'b1;
      o_p_data     <= '0;
      o_data_valid <= 1'b0;
      o_stop_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad      <= 1'b0;
      par_err_q    <= 1'b0;
`endif
    end else begin
      rx_meta      <= i_rx_in;
      rx_s         <= rx_meta;
      rx_prev      <= rx_s;
      o_data_valid <= 1'b0;
      o_stop_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
`endif
      if (state != S_IDLE) begin
        if (tick_cnt == TICK_A) samp_a <= rx_s;
        if (tick_cnt == TICK_B) samp_b <= rx_s;
        tick_cnt <= bit_end ? '0 : tick_cnt + 1'b1;
      end

      case (state)
        S_IDLE: begin
          // A fresh 1->0 edge is required, so a line stuck low never retriggers.
          if (rx_prev && !rx_s) begin
            state    <= S_START;
            tick_cnt <= '0;
            bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= i_par_en;
            par_typ_q <= i_par_typ;
            par_bad   <= 1'b0;
`endif
          end
        end
        S_START: begin
          if (decide && vote) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
          end else if (bit_end) begin
            state <= S_DATA;
          end
        end
        S_DATA: begin
          if (decide) shift_reg <= {vote, shift_reg[DATA_WIDTH-1:1]};
          if (bit_end) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              state   <= par_en_q ? S_PARITY : S_STOP;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (decide && (vote != (^shift_reg ^ par_typ_q))) par_bad <= 1'b1;
          if (bit_end) state <= S_STOP;
        end
`endif
        S_STOP: begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          if (decide) begin
            state    <= S_IDLE;
            tick_cnt <= '0;
            if (!vote) begin
              o_stop_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              par_err_q  <= par_bad;
            end else if (par_bad) begin
              par_err_q  <= 1'b1;
`endif
            end else begin
              o_p_data     <= shift_reg;
              o_data_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb/tb_uart_rx_deserializer.sv - self-checking bench for uart_rx_deserializer
module tb_uart_rx_deserializer;
  localparam int W = 8;
  localparam int P = 8;
  localparam int M = P / 2;
  localparam int LAT = (W + 1) * P + M + 5;

  logic         clk = 1'b0;
  logic         rst, rx, par_en, par_typ;
  logic [W-1:0] p_data;
  logic         data_valid, par_err, stop_err, busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0, start_cyc = 0, valid_cyc = 0;
  int n_valid = 0, n_par = 0, n_stop = 0, n_busy = 0;
  logic [W-1:0] got_q[$];
  logic [W-1:0] model_data;

  uart_rx_deserializer #(.DATA_WIDTH(W), .PRESCALE(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_in(rx), .i_par_en(par_en), .i_par_typ(par_typ),
    .o_p_data(p_data), .o_data_valid(data_valid), .o_par_err(par_err),
    .o_stop_err(stop_err), .o_busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      n_valid++;
      valid_cyc = cyc;
      got_q.push_back(p_data);
    end
    if (par_err === 1'b1) n_par++;
    if (stop_err === 1'b1) n_stop++;
    if (busy === 1'b1) n_busy++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit par_active(input bit pe);
`ifdef UART_RX_PARITY_EN
    return pe;
`else
    return 1'b0;
`endif
  endfunction

  task automatic wait_bits(input int n);
    repeat (n * P) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt, input bit pbit,
                            input bit stop, input bit flip, input int low_after);
    par_en = pe;
    par_typ = pt;
    start_cyc = cyc;
    rx = 1'b0;
    wait_bits(1);
    for (int i = 0; i < W; i++) begin
      if (flip && i == 2) begin
        par_en = !pe;
        par_typ = !pt;
      end
      rx = d[i];
      wait_bits(1);
    end
    if (par_active(pe)) begin
      rx = pbit;
      wait_bits(1);
    end
    rx = stop;
    wait_bits(1);
    if (low_after > 0) begin
      rx = 1'b0;
      wait_bits(low_after);
    end
    rx = 1'b1;
  endtask

  // Reference outcome: ones in data plus parity bit must be even (typ=0) or odd (typ=1).
  task automatic frame_and_check(input string tag, input logic [W-1:0] d, input bit pe, input bit pt,
                                 input bit pbit, input bit stop, input bit flip, input int low_after);
    int v0, p0, s0, ev, ep, es;
    bit par_ok;
    v0 = n_valid; p0 = n_par; s0 = n_stop;
    send_frame(d, pe, pt, pbit, stop, flip, low_after);
    wait_bits(2);
    par_ok = !par_active(pe) || (((($countones(d) + int'(pbit)) % 2) == int'(pt)));
    es = stop ? 0 : 1;
    ep = par_ok ? 0 : 1;
    ev = (stop && par_ok) ? 1 : 0;
    if (ev == 1) model_data = d;
    check({tag, "_valid"}, n_valid - v0, ev);
    check({tag, "_parerr"}, n_par - p0, ep);
    check({tag, "_stoperr"}, n_stop - s0, es);
    check({tag, "_data"}, p_data, model_data);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int b0, v0, p0, s0;
    logic [W-1:0] d;
    bit pe, pt, pb, st, fl;
    rst = 1'b1; rx = 1'b1; par_en = 1'b0; par_typ = 1'b0;
    model_data = '0;
    repeat (3) @(negedge clk);
    check("rst_data", p_data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_parerr", par_err, 0);
    check("rst_stoperr", stop_err, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    frame_and_check("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("t1_latency", valid_cyc - start_cyc, LAT);

`ifdef UART_RX_PARITY_EN
    frame_and_check("t2_3c_good", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("t2_latency", valid_cyc - start_cyc, LAT + P);
    frame_and_check("t2_3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    frame_and_check("t2_odd_good", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    frame_and_check("t2_flip_midframe", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    frame_and_check("t2_stop_and_par", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
`else
    frame_and_check("t6_96_nopar", 8'h96, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
`endif

    b0 = n_busy; v0 = n_valid; p0 = n_par; s0 = n_stop;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    wait_bits(3);
    check("t3_busy_seen", (n_busy - b0) > 0, 1);
    check("t3_busy_short", (n_busy - b0) < (M + 4), 1);
    check("t3_no_pulses", (n_valid - v0) + (n_par - p0) + (n_stop - s0), 0);

    frame_and_check("t4_81_stoperr", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    frame_and_check("t4_7e", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    par_en = 1'b0;
    rx = 1'b0;
    wait_bits(1);
    rx = 1'b1;
    wait_bits(3);
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", busy, 0);
    check("t5_data", p_data, 0);
    check("t5_pulses", {data_valid, par_err, stop_err}, 0);
    rst = 1'b0;
    model_data = '0;
    wait_bits(2);
    frame_and_check("t5_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    got_q.delete();
    p0 = n_par;
    send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    send_frame(8'h69, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    wait_bits(2);
    check("t6_b2b_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check("t6_b2b_first", got_q[0], 8'h96);
      check("t6_b2b_second", got_q[1], 8'h69);
    end
    check("t6_b2b_parerr", n_par - p0, 0);
    model_data = 8'h69;

    for (int k = 0; k < 10; k++) begin
      d  = W'($urandom);
      pe = 1'($urandom);
      pt = 1'($urandom);
      pb = 1'($urandom);
      st = ($urandom_range(0, 4) != 0);
      fl = 1'($urandom);
      frame_and_check($sformatf("rnd%0d_%02h", k, d), d, pe, pt, pb, st, fl, 0);
      repeat ($urandom_range(1, 2 * P)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
